// File: rtl/quad_decoder_pkg.sv
// Shared types, Gray-code constants and transition classifier for the quadrature decoder.
package quad_pkg;

   typedef enum logic {INIT, RUN} quad_state_t;

   // {A,B} codes in forward (up) order
   localparam logic [1:0] GRAY_SEQ0 = 2'b00;
   localparam logic [1:0] GRAY_SEQ1 = 2'b10;
   localparam logic [1:0] GRAY_SEQ2 = 2'b11;
   localparam logic [1:0] GRAY_SEQ3 = 2'b01;

   typedef struct packed {
      logic valid;
      logic up;
      logic illegal;
   } quad_dir_t;

   function automatic logic [1:0] gray_next(input logic [1:0] code);
      logic [1:0] nxt;
      case (code)
         GRAY_SEQ0: nxt = GRAY_SEQ1;
         GRAY_SEQ1: nxt = GRAY_SEQ2;
         GRAY_SEQ2: nxt = GRAY_SEQ3;
         default:   nxt = GRAY_SEQ0;
      endcase
      return nxt;
   endfunction

   function automatic quad_dir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
      quad_dir_t r;
      r = '0;
      if (cur == gray_next(prev)) begin
         r.valid = 1'b1;
         r.up    = 1'b1;
      end else if (prev == gray_next(cur)) begin
         r.valid = 1'b1;
      end else if ((prev ^ cur) == 2'b11) begin
         r.illegal = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Quadrature inputs and decoded step/direction/error outputs.
interface quad_decoder_if;
   logic a_in;
   logic b_in;
   logic step;
   logic up;
   logic err;

   modport master (output a_in, output b_in, input step, input up, input err);
   modport slave  (input a_in, input b_in, output step, output up, output err);
endinterface

// File: rtl/quad_decoder_filter.sv
// One quadrature bit: synchroniser chain followed by a consecutive-cycle debounce filter.
module quad_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic filt,
   output logic busy
);

   localparam int CW = $clog2(FILTER_LEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   synced;

   assign synced = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
         cnt  <= '0;
         filt <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], din};
         if (synced == filt) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filt <= synced;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // A pending difference counts as busy even before the counter has left zero
   assign busy = (cnt != '0) || (synced != filt);

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: filtered A/B pair into registered step/up/err pulses.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic           clk,
   input  logic           rst,
   quad_decoder_if.slave  bus
);
   // state | meaning
   // INIT  | settle timer and filters after reset; latch first {A,B} as prev
   // RUN   | decode each filtered {A,B} change against prev

   localparam int TW = $clog2(FILTER_LEN + 1);

   logic        filt_a, filt_b, busy_a, busy_b;
   logic [1:0]  cur;
   quad_state_t state, state_d;
   logic [1:0]  prev, prev_d;
   logic [TW-1:0] init_cnt, init_cnt_d;
   logic        step_q, step_d, up_q, up_d, err_q, err_d;
   quad_dir_t   dir;

   quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
      .clk(clk), .rst(rst), .din(bus.a_in), .filt(filt_a), .busy(busy_a)
   );

   quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
      .clk(clk), .rst(rst), .din(bus.b_in), .filt(filt_b), .busy(busy_b)
   );

   assign cur = {filt_a, filt_b};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= INIT;
         prev     <= '0;
         init_cnt <= TW'(FILTER_LEN);
         step_q   <= 1'b0;
         up_q     <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state    <= state_d;
         prev     <= prev_d;
         init_cnt <= init_cnt_d;
         step_q   <= step_d;
         up_q     <= up_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d    = state;
      prev_d     = prev;
      init_cnt_d = init_cnt;
      step_d     = 1'b0;
      err_d      = 1'b0;
      up_d       = up_q;
      dir        = quad_dir(prev, cur);
      case (state)
         INIT: begin
            if (init_cnt != '0) begin
               init_cnt_d = init_cnt - TW'(1);
            end else if (!busy_a && !busy_b) begin
               prev_d  = cur;
               state_d = RUN;
            end
         end
         RUN: begin
            prev_d = cur;
            step_d = dir.valid;
            err_d  = dir.illegal;
            if (dir.valid) up_d = dir.up;
         end
         default: state_d = INIT;
      endcase
   end

   assign bus.step = step_q;
   assign bus.up   = up_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder with default parameters.
module tb_quad_decoder;
   import quad_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   step_cnt = 0;
   int   err_cnt = 0;
   int   both_cnt = 0;

   always #5 clk = ~clk;

   quad_decoder_if bus();

   quad_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always @(negedge clk) begin
      if (bus.step === 1'b1) step_cnt++;
      if (bus.err === 1'b1) err_cnt++;
      if (bus.step === 1'b1 && bus.err === 1'b1) both_cnt++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a new level, expect exactly one step 7 edges later with the given direction
   task automatic edge_step(input logic na, input logic nb, input logic want_up, input string tag);
      bus.a_in = na;
      bus.b_in = nb;
      wait_neg(6);
      chk({tag, " early"}, 8'(bus.step), 8'd0);
      wait_neg(1);
      chk({tag, " step"}, 8'(bus.step), 8'd1);
      chk({tag, " up"}, 8'(bus.up), 8'(want_up));
      chk({tag, " err"}, 8'(bus.err), 8'd0);
      wait_neg(1);
      chk({tag, " width"}, 8'(bus.step), 8'd0);
   endtask

   initial begin
      int s0;
      int e0;

      // Reset with both inputs high
      rst = 1'b0;
      bus.a_in = 1'b1;
      bus.b_in = 1'b1;
      wait_neg(3);
      chk("rst step", 8'(bus.step), 8'd0);
      chk("rst err", 8'(bus.err), 8'd0);
      chk("rst up", 8'(bus.up), 8'd1);
      chk("rst state", 8'(dut.state), 8'(INIT));
      s0 = step_cnt;
      e0 = err_cnt;
      rst = 1'b1;
      wait_neg(3);
      chk("init hold", 8'(dut.state), 8'(INIT));
      wait_neg(12);
      #1;
      chk("init to run", 8'(dut.state), 8'(RUN));
      chk("init prev", 8'(dut.prev), 8'h3);
      chk("init no step", 8'(step_cnt - s0), 8'd0);
      chk("init no err", 8'(err_cnt - e0), 8'd0);

      // Restart from 00
      @(negedge clk);
      rst = 1'b0;
      bus.a_in = 1'b0;
      bus.b_in = 1'b0;
      wait_neg(2);
      rst = 1'b1;
      wait_neg(15);
      chk("run 00", 8'(dut.state), 8'(RUN));
      chk("prev 00", 8'(dut.prev), 8'h0);

      // Forward rotation
      s0 = step_cnt;
      edge_step(1'b1, 1'b0, 1'b1, "fwd 10");
      edge_step(1'b1, 1'b1, 1'b1, "fwd 11");
      edge_step(1'b0, 1'b1, 1'b1, "fwd 01");
      edge_step(1'b0, 1'b0, 1'b1, "fwd 00");
      #1;
      chk("fwd count", 8'(step_cnt - s0), 8'd4);

      // Reverse rotation
      s0 = step_cnt;
      edge_step(1'b0, 1'b1, 1'b0, "rev 01");
      edge_step(1'b1, 1'b1, 1'b0, "rev 11");
      edge_step(1'b1, 1'b0, 1'b0, "rev 10");
      wait_neg(5);
      chk("rev up hold", 8'(bus.up), 8'd0);
      chk("rev idle", 8'(bus.step), 8'd0);
      #1;
      chk("rev count", 8'(step_cnt - s0), 8'd3);
      edge_step(1'b0, 1'b0, 1'b0, "ret 00");

      // Glitch rejection
      #1;
      s0 = step_cnt;
      e0 = err_cnt;
      bus.a_in = 1'b1;
      wait_neg(3);
      bus.a_in = 1'b0;
      wait_neg(12);
      #1;
      chk("glitch3 step", 8'(step_cnt - s0), 8'd0);
      chk("glitch3 err", 8'(err_cnt - e0), 8'd0);
      s0 = step_cnt;
      bus.a_in = 1'b1;
      wait_neg(4);
      bus.a_in = 1'b0;
      wait_neg(3);
      chk("glitch4 rise", 8'(bus.step), 8'd1);
      chk("glitch4 rise up", 8'(bus.up), 8'd1);
      wait_neg(4);
      chk("glitch4 fall", 8'(bus.step), 8'd1);
      chk("glitch4 fall up", 8'(bus.up), 8'd0);
      wait_neg(4);
      #1;
      chk("glitch4 count", 8'(step_cnt - s0), 8'd2);

      // Illegal double-bit transition 00 -> 11
      s0 = step_cnt;
      e0 = err_cnt;
      bus.a_in = 1'b1;
      bus.b_in = 1'b1;
      wait_neg(7);
      chk("illegal err", 8'(bus.err), 8'd1);
      chk("illegal step", 8'(bus.step), 8'd0);
      chk("illegal up", 8'(bus.up), 8'd0);
      wait_neg(1);
      chk("illegal width", 8'(bus.err), 8'd0);
      wait_neg(2);
      #1;
      chk("illegal err count", 8'(err_cnt - e0), 8'd1);
      chk("illegal step count", 8'(step_cnt - s0), 8'd0);
      chk("illegal prev", 8'(dut.prev), 8'h3);
      @(negedge clk);
      edge_step(1'b0, 1'b1, 1'b1, "after illegal");

      // Reset while step is high
      bus.b_in = 1'b0;
      wait_neg(7);
      chk("pre-reset step", 8'(bus.step), 8'd1);
      rst = 1'b0;
      #1;
      chk("async step", 8'(bus.step), 8'd0);
      chk("async up", 8'(bus.up), 8'd1);
      chk("async err", 8'(bus.err), 8'd0);
      chk("async state", 8'(dut.state), 8'(INIT));
      bus.a_in = 1'b1;
      bus.b_in = 1'b1;
      wait_neg(3);
      s0 = step_cnt;
      e0 = err_cnt;
      rst = 1'b1;
      wait_neg(20);
      #1;
      chk("post-reset no step", 8'(step_cnt - s0), 8'd0);
      chk("post-reset no err", 8'(err_cnt - e0), 8'd0);
      chk("post-reset state", 8'(dut.state), 8'(RUN));
      chk("post-reset prev", 8'(dut.prev), 8'h3);
      @(negedge clk);
      edge_step(1'b0, 1'b1, 1'b1, "post-reset 01");
      #1;
      chk("step err exclusive", 8'(both_cnt), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
